// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches words over an imem req/ack handshake and queues
// {instruction, PC} pairs for decode; branch redirects flush the queue. Rev 1.0
`default_nettype none

module fetch_unit #(
  parameter int          DW       = 16,
  parameter int          AW       = 16,
  parameter int          DEPTH    = 2,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int          PC_STEP  = 4
) (
  input  logic          clock_i,
  input  logic          reset_i,
  output logic          imem_req_o,
  output logic [AW-1:0] imem_addr_o,
  input  logic          imem_ack_i,
  input  logic [DW-1:0] imem_rdata_i,
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_pc_i,
  output logic          ir_valid_o,
  output logic [DW-1:0] ir_o,
  output logic [AW-1:0] ir_pc_o,
  input  logic          ir_ready_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [AW-1:0] STEP = AW'(PC_STEP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic          req_q;

  logic [DW-1:0] buf_ir_q [DEPTH];
  logic [AW-1:0] buf_pc_q [DEPTH];

  logic          pop;
  logic          push;
  logic [CW-1:0] occ_after_pop;
  logic [CW-1:0] occ_next;
  logic          can_issue;
  logic          has_space;

  assign ir_valid_o  = (count_q != '0);
  assign ir_o        = buf_ir_q[rd_q];
  assign ir_pc_o     = buf_pc_q[rd_q];
  assign imem_req_o  = req_q;
  assign imem_addr_o = req_addr_q;

  // A redirect suppresses both queue operations: the queue is being flushed.
  assign pop  = ir_valid_o & ir_ready_i & ~redirect_i;
  assign push = (state_q == ST_REQ) & imem_ack_i & ~redirect_i;

  assign occ_after_pop = count_q - CW'(pop);
  assign occ_next      = occ_after_pop + CW'(push);
  assign can_issue     = (occ_after_pop < FULL);
  assign has_space     = (occ_next < FULL);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    count_d    = occ_next;
    rd_d       = pop  ? rd_q + PW'(1) : rd_q;
    wr_d       = push ? wr_q + PW'(1) : wr_q;

    if (redirect_i) begin
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
      // An un-acked request cannot be withdrawn; let it finish and throw its data away.
      if ((state_q != ST_IDLE) && !imem_ack_i) begin
        state_d = ST_DROP;
        pc_d    = redirect_pc_i;
      end else begin
        state_d    = ST_REQ;
        req_addr_d = redirect_pc_i;
        pc_d       = redirect_pc_i + STEP;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (can_issue) begin
            state_d    = ST_REQ;
            req_addr_d = pc_q;
            pc_d       = pc_q + STEP;
          end
        end
        ST_REQ: begin
          if (imem_ack_i) begin
            if (has_space) begin
              req_addr_d = pc_q;
              pc_d       = pc_q + STEP;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (imem_ack_i) begin
            if (can_issue) begin
              state_d    = ST_REQ;
              req_addr_d = pc_q;
              pc_d       = pc_q + STEP;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      req_q      <= (state_d != ST_IDLE);
    end
  end

  // Storage carries no reset; ir_valid_o qualifies its contents.
  always_ff @(posedge clock_i) begin
    if (push) begin
      buf_ir_q[wr_q] <= imem_rdata_i;
      buf_pc_q[wr_q] <= req_addr_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit fill, backpressure, ack latency,
// redirect handling and PC wrap; every expected value is hand-computed.
`default_nettype none

module tb_fetch_unit;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;

  // Instance A: default RESET_PC, bench-controlled memory
  logic        reset_a, req_a, ack_a, redirect_a, valid_a, ready_a;
  logic [15:0] addr_a, rdata_a, redirect_pc_a, ir_a, ir_pc_a;

  // Instance B: RESET_PC = FFF8 for wrap and mid-request reset
  logic        reset_b, req_b, ack_b, valid_b, ready_b, ack_en_b;
  logic [15:0] addr_b, rdata_b, ir_b, ir_pc_b;

  logic        auto_mode, man_ack;
  logic [15:0] man_rdata;
  int          lat;
  int          wait_cnt;

  assign ack_a   = auto_mode ? (req_a && (wait_cnt >= lat)) : man_ack;
  assign rdata_a = auto_mode ? (addr_a + 16'h1000) : man_rdata;
  assign ack_b   = req_b & ack_en_b;
  assign rdata_b = addr_b + 16'h1000;

  always @(posedge clock) begin
    if (reset_a || !req_a || ack_a) wait_cnt <= 0;
    else                           wait_cnt <= wait_cnt + 1;
  end

  fetch_unit u_dut_a (
    .clock_i(clock), .reset_i(reset_a),
    .imem_req_o(req_a), .imem_addr_o(addr_a), .imem_ack_i(ack_a), .imem_rdata_i(rdata_a),
    .redirect_i(redirect_a), .redirect_pc_i(redirect_pc_a),
    .ir_valid_o(valid_a), .ir_o(ir_a), .ir_pc_o(ir_pc_a), .ir_ready_i(ready_a)
  );

  fetch_unit #(.RESET_PC(16'hFFF8)) u_dut_b (
    .clock_i(clock), .reset_i(reset_b),
    .imem_req_o(req_b), .imem_addr_o(addr_b), .imem_ack_i(ack_b), .imem_rdata_i(rdata_b),
    .redirect_i(1'b0), .redirect_pc_i(16'h0000),
    .ir_valid_o(valid_b), .ir_o(ir_b), .ir_pc_o(ir_pc_b), .ir_ready_i(ready_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_a_seq();
    reset_a = 1'b1;
    tick();
    tick();
    reset_a = 1'b0;
  endtask

  initial begin
    reset_a = 1'b1; redirect_a = 1'b0; redirect_pc_a = '0; ready_a = 1'b1;
    auto_mode = 1'b1; lat = 0; man_ack = 1'b0; man_rdata = '0;
    reset_b = 1'b1; ready_b = 1'b1; ack_en_b = 1'b1;

    // 1: sequential fetch with single-cycle ack
    reset_a_seq();
    check("t1 reset req", req_a, 0);
    check("t1 reset valid", valid_a, 0);
    tick();
    check("t1 c1 req", req_a, 1);
    check("t1 c1 addr", addr_a, 16'h0000);
    check("t1 c1 valid", valid_a, 0);
    tick();
    check("t1 c2 addr", addr_a, 16'h0004);
    check("t1 c2 valid", valid_a, 1);
    check("t1 c2 ir_pc", ir_pc_a, 16'h0000);
    check("t1 c2 ir", ir_a, 16'h1000);
    tick();
    check("t1 c3 addr", addr_a, 16'h0008);
    check("t1 c3 ir_pc", ir_pc_a, 16'h0004);
    check("t1 c3 ir", ir_a, 16'h1004);
    tick();
    check("t1 c4 addr", addr_a, 16'h000C);
    check("t1 c4 ir_pc", ir_pc_a, 16'h0008);
    check("t1 c4 ir", ir_a, 16'h1008);

    // 2: backpressure fills the 2-entry buffer
    ready_a = 1'b0;
    reset_a_seq();
    tick();
    check("t2 c1 addr", addr_a, 16'h0000);
    tick();
    check("t2 c2 addr", addr_a, 16'h0004);
    check("t2 c2 ir_pc", ir_pc_a, 16'h0000);
    tick();
    check("t2 full req", req_a, 0);
    check("t2 full valid", valid_a, 1);
    tick();
    check("t2 held req", req_a, 0);
    check("t2 held ir_pc", ir_pc_a, 16'h0000);
    ready_a = 1'b1;
    tick();
    check("t2 resume req", req_a, 1);
    check("t2 resume addr", addr_a, 16'h0008);
    check("t2 pop ir_pc", ir_pc_a, 16'h0004);
    check("t2 pop ir", ir_a, 16'h1004);
    tick();
    check("t2 next ir_pc", ir_pc_a, 16'h0008);

    // 3: ack latency of 3 cycles
    lat = 2;
    reset_a_seq();
    tick();
    check("t3 c1 addr", addr_a, 16'h0000);
    tick();
    check("t3 c2 addr", addr_a, 16'h0000);
    check("t3 c2 req", req_a, 1);
    tick();
    check("t3 c3 addr", addr_a, 16'h0000);
    check("t3 c3 valid", valid_a, 0);
    tick();
    check("t3 c4 addr", addr_a, 16'h0004);
    check("t3 c4 ir_pc", ir_pc_a, 16'h0000);
    tick();
    check("t3 c5 valid", valid_a, 0);
    check("t3 c5 addr", addr_a, 16'h0004);
    tick();
    tick();
    check("t3 c7 addr", addr_a, 16'h0008);
    check("t3 c7 ir_pc", ir_pc_a, 16'h0004);
    check("t3 c7 ir", ir_a, 16'h1004);

    // 4: redirect while a request is outstanding
    lat = 0;
    reset_a_seq();
    tick();
    tick();
    tick();
    check("t4 pre addr", addr_a, 16'h0008);
    check("t4 pre valid", valid_a, 1);
    auto_mode = 1'b0; man_ack = 1'b0; ready_a = 1'b0;
    redirect_a = 1'b1; redirect_pc_a = 16'h0040;
    tick();
    redirect_a = 1'b0;
    check("t4 flush valid", valid_a, 0);
    check("t4 drop addr", addr_a, 16'h0008);
    check("t4 drop req", req_a, 1);
    tick();
    check("t4 wait valid", valid_a, 0);
    man_ack = 1'b1; man_rdata = 16'hDEAD;
    tick();
    man_ack = 1'b0;
    check("t4 new addr", addr_a, 16'h0040);
    check("t4 no DEAD valid", valid_a, 0);
    auto_mode = 1'b1; ready_a = 1'b1;
    tick();
    check("t4 first valid", valid_a, 1);
    check("t4 first ir_pc", ir_pc_a, 16'h0040);
    check("t4 first ir", ir_a, 16'h1040);

    // 5: redirect coinciding with ack and pop
    redirect_a = 1'b1; redirect_pc_a = 16'h0080;
    tick();
    redirect_a = 1'b0;
    check("t5 flushed valid", valid_a, 0);
    check("t5 addr", addr_a, 16'h0080);
    check("t5 req", req_a, 1);
    tick();
    check("t5 next ir_pc", ir_pc_a, 16'h0080);
    check("t5 next addr", addr_a, 16'h0084);

    // 6: PC wrap from FFF8, then reset mid-request
    tick();
    reset_b = 1'b0;
    tick();
    check("t6 c1 addr", addr_b, 16'hFFF8);
    tick();
    check("t6 c2 addr", addr_b, 16'hFFFC);
    check("t6 c2 ir_pc", ir_pc_b, 16'hFFF8);
    check("t6 c2 ir", ir_b, 16'h0FF8);
    tick();
    check("t6 wrap addr", addr_b, 16'h0000);
    check("t6 c3 ir_pc", ir_pc_b, 16'hFFFC);
    ack_en_b = 1'b0;
    tick();
    check("t6 pend req", req_b, 1);
    check("t6 pend addr", addr_b, 16'h0000);
    reset_b = 1'b1;
    tick();
    check("t6 rst req", req_b, 0);
    check("t6 rst valid", valid_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
